seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexed scan controller for the clock's multi-digit seven-segment display. It holds a BCD digit per display position and drives one shared `bcd_to_7seg` decoder for one digit at a time. It gates the decoder's segment output onto the shared segment bus with a one-hot digit enable, and inserts a blanking gap between digits to prevent ghosting. The upstream timekeeping logic loads new digits through a valid/ready write port and a commit request, so the displayed frame never tears.

## Interface
- `NUM_DIGITS`, 4: display positions; index 0 is the least significant digit.
- `SCAN_DIV`, 1000: clk cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, 16: cycles at the start of each slot with all digits off; 1 ≤ `BLANK_CYCLES` < `SCAN_DIV`.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: digit write request.
- `wr_ready` out 1: write accepted when high together with `wr_valid`.
- `wr_addr` in $clog2(NUM_DIGITS): digit index to write.
- `wr_data` in 4: BCD value for the write.
- `commit` in 1: pulse requesting a shadow→active copy at the next frame boundary.
- `frame_start` out 1: one-cycle pulse on the first cycle of digit 0's slot.
- `bcd_out` out 4: BCD value to the shared decoder.
- `seg_in` in 7: decoder output (combinational from `bcd_out`).
- `seg_out` out 7: segment bus, active-high, order {a..g}.
- `dig_en` out NUM_DIGITS: one-hot digit enable, active-high; all-zero while blanking.

## Operation
- Storage: a shadow array (write target) and an active array (display source), NUM_DIGITS×4 bits each.
- Write port: on `wr_valid && wr_ready`, `shadow[wr_addr] <= wr_data`.
  - Writes with `wr_addr` ≥ NUM_DIGITS are accepted and dropped.
  - Values >9 are stored unchanged; the decoder displays them blank.
- Commit: a `commit` pulse sets `pending`; extra pulses while pending merge into one.
- Boundary copy: at the slot boundary into digit 0 with `pending` set, active ← shadow and `pending` clears.
  - `wr_ready` is low in that copy cycle only, so no write can race the copy.
  - A `commit` arriving in the copy cycle sets `pending` again for the next frame.
- FSM has two states, per-slot counter `cnt` and digit index `idx`.
  - BLANK: `dig_en`=0 and `seg_out`=0; `bcd_out` = active[idx]. After BLANK_CYCLES → DRIVE.
  - DRIVE: `dig_en` = 1<<idx; `seg_out` = `seg_in`. After SCAN_DIV−BLANK_CYCLES cycles → BLANK.
  - On DRIVE→BLANK, `idx` advances; it wraps from NUM_DIGITS−1 to 0.
- Scan order: 0,1,…,NUM_DIGITS−1, then repeat.
- Reset (async, any time, including mid-slot):
  - state BLANK, `idx`=0, `cnt`=0, `pending`=0, shadow and active arrays 0.
  - Outputs: `bcd_out`=0, `seg_out`=0, `dig_en`=0, `wr_ready`=1, `frame_start`=0.
  - The first slot after reset is a normal digit-0 slot; `frame_start` pulses on the first clock edge after release.

## Timing
- All outputs are registered.
- `bcd_out` updates on the first BLANK cycle of a slot. `seg_in` therefore settles BLANK_CYCLES before DRIVE samples it.
- `seg_out` and `dig_en` change on the same edge; they are never skewed.
- Slot = SCAN_DIV cycles; frame = NUM_DIGITS×SCAN_DIV cycles.
- `frame_start`, the boundary copy, and `wr_ready`=0 all fall on the same cycle.
- Commit latency: from the `commit` pulse to the new values appearing on `bcd_out` is at most one frame plus one cycle.

## Configuration
- The macro is `SEG_SCAN_LEADING_ZERO_BLANK_EN`.
- Defined: leading-zero blanking is on.
  - Starting from digit NUM_DIGITS−1 and moving down, each active digit equal to 0 is suppressed until the first nonzero digit.
  - For a suppressed digit, `dig_en` stays 0 through its DRIVE phase; slot timing is unchanged.
  - Digit 0 is never suppressed.
- Undefined: every digit is driven in its slot.

## Structure
- Package `seg_scan_pkg` holds:
  - the `scan_state_t` enum (BLANK, DRIVE);
  - the `bcd_t` 4-bit typedef;
  - the `BCD_ZERO` constant.
- One sub-module, `seg_scan_timer`, owns `cnt`, `idx`, the FSM, and the `frame_start` and boundary strobes.
- The top level owns the register arrays, the write/commit logic, and output gating.
- The decoder is instantiated outside this block.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
- Reset release, no writes: `dig_en` shows 0000 for 2 cycles, then 0001 for 6, then 0000, then 0010. `frame_start` pulses every 32 cycles. `bcd_out`=0 throughout.
- Write 1,2,3,4 to addresses 0–3, then `commit`: from the next `frame_start`, `bcd_out` steps 1,2,3,4, one value per 8-cycle slot.
- Write 9 to address 0 without `commit`: the display stays unchanged for 3 frames.
- `commit` pulsed in the cycle before `frame_start`: the copy happens at that boundary and `wr_ready`=0 for exactly that cycle. A `wr_valid` held through the copy cycle is accepted on the next cycle.
- Shadow set to {0,0,0,7} with index 3 as MSD, then commit:
  - macro defined: `dig_en` stays 0 in slots 1–3 and is 0001 in slot 0;
  - macro undefined: all four slots are enabled.
- `rst_n` asserted mid-DRIVE of digit 2: `dig_en`, `seg_out` and `bcd_out` go to 0 immediately. After release, scanning restarts at digit 0 with `frame_start`.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the seven-segment scan controller.
//   scan_state_t : slot phase (BLANK = all digits off, DRIVE = one digit lit)
//   bcd_t        : one BCD digit as stored in the shadow/active arrays
//   BCD_ZERO     : the value held in every digit after reset
package seg_scan_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_ZERO = 4'd0;

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: slot/digit sequencer for the scan controller.
// The registers (state_r, cnt_r, idx_r) describe the slot position that the
// controller's registered outputs will present after the next clock edge, so
// the reset value (BLANK, cnt 0, idx 0) becomes the first cycle of digit 0's
// slot and frame_start pulses right after the first edge following reset.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   drive        : upcoming cycle is in the DRIVE phase
//   idx          : digit index of the upcoming cycle
//   boundary     : upcoming cycle is the first cycle of digit 0's slot
//   frame_start  : registered one-cycle pulse on the first cycle of a frame
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16,
    localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CW = $clog2(SCAN_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          drive,
    output logic [AW-1:0] idx,
    output logic          boundary,
    output logic          frame_start
);

    localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(SCAN_DIV - 1);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_DIGITS - 1);

    scan_state_t   state_r;
    scan_state_t   state_n;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_n;
    logic [AW-1:0] idx_r;
    logic [AW-1:0] idx_n;
    logic          frame_start_r;

    // Next-state logic: cnt runs across the whole slot; BLANK hands over to
    // DRIVE after BLANK_CYCLES, DRIVE ends the slot and advances the digit.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r + CW'(1);
        idx_n   = idx_r;
        case (state_r)
            BLANK: begin
                if (cnt_r == LAST_BLANK) begin
                    state_n = DRIVE;
                end else begin
                    state_n = BLANK;
                end
            end
            DRIVE: begin
                if (cnt_r == LAST_CNT) begin
                    state_n = BLANK;
                    cnt_n   = CW'(0);
                    if (idx_r == LAST_IDX) begin
                        idx_n = AW'(0);
                    end else begin
                        idx_n = idx_r + AW'(1);
                    end
                end else begin
                    state_n = DRIVE;
                end
            end
            default: begin
                state_n = BLANK;
                cnt_n   = CW'(0);
                idx_n   = AW'(0);
            end
        endcase
    end

    // State, counter and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BLANK;
            cnt_r   <= CW'(0);
            idx_r   <= AW'(0);
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            idx_r   <= idx_n;
        end
    end

    assign boundary = (state_r == BLANK) && (cnt_r == CW'(0)) && (idx_r == AW'(0));
    assign drive    = (state_r == DRIVE);
    assign idx      = idx_r;

    // Registered frame pulse, aligned with the controller's other outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= boundary;
        end
    end

    assign frame_start = frame_start_r;

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scan controller.
// Holds a shadow digit array (written through wr_*) and an active array
// (displayed). A commit request is copied shadow->active at the next frame
// boundary so a frame never shows a mix of old and new digits.
// Optional feature: define SEG_SCAN_LEADING_ZERO_BLANK_EN to suppress leading
// zero digits (digit 0 is always shown).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_valid/wr_ready   : digit write handshake; wr_addr selects, wr_data is BCD
//   commit              : request a shadow->active copy at the next frame start
//   frame_start         : one-cycle pulse on the first cycle of digit 0's slot
//   bcd_out             : digit value to the external decoder
//   seg_in              : decoder output for bcd_out
//   seg_out, dig_en     : segment bus and one-hot digit enable (all zero in blank)
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16,
    localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  commit,
    output logic                  frame_start,
    output logic [3:0]            bcd_out,
    input  logic [6:0]            seg_in,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_en
);

    bcd_t                  shadow_r [NUM_DIGITS];
    bcd_t                  shadow_n [NUM_DIGITS];
    bcd_t                  active_r [NUM_DIGITS];
    logic                  pending_r;
    logic                  wr_ready_r;
    bcd_t                  bcd_out_r;
    logic [6:0]            seg_out_r;
    logic [NUM_DIGITS-1:0] dig_en_r;

    logic                  drive_s;
    logic [AW-1:0]         idx_s;
    logic                  boundary_s;
    logic                  wr_fire_s;
    logic                  addr_ok_s;
    logic                  copy_s;
    logic                  lit_s;
    logic                  lead_s;
    logic [NUM_DIGITS-1:0] suppress_s;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .drive       (drive_s),
        .idx         (idx_s),
        .boundary    (boundary_s),
        .frame_start (frame_start)
    );

    // Write port and copy decision. The copy takes the shadow contents
    // including a write landing on the same edge, so the new frame is complete.
    always_comb begin
        wr_fire_s = wr_valid && wr_ready_r;
        addr_ok_s = ({1'b0, wr_addr} < (AW + 1)'(NUM_DIGITS));
        shadow_n  = shadow_r;
        if (wr_fire_s && addr_ok_s) begin
            shadow_n[wr_addr] = wr_data;
        end else begin
            shadow_n = shadow_r;
        end
        copy_s = boundary_s && (pending_r || commit);
    end

    // Shadow (write target) and active (display source) digit arrays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_r[i] <= BCD_ZERO;
                active_r[i] <= BCD_ZERO;
            end
        end else begin
            shadow_r <= shadow_n;
            if (copy_s) begin
                active_r <= shadow_n;
            end else begin
                active_r <= active_r;
            end
        end
    end

    // Commit tracking: a copy consumes every request seen so far; a commit
    // arriving after the copy edge is held for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 1'b0;
        end else if (copy_s) begin
            pending_r <= 1'b0;
        end else if (commit) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Leading-zero suppression, scanning from the most significant digit down.
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    always_comb begin
        lead_s     = 1'b1;
        suppress_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead_s        = lead_s && (active_r[i] == BCD_ZERO);
            suppress_s[i] = lead_s;
        end
    end
`else
    // Every digit is shown in its slot.
    always_comb begin
        lead_s     = 1'b0;
        suppress_s = {NUM_DIGITS{1'b0}};
    end
`endif

    assign lit_s = drive_s && !suppress_s[idx_s];

    // Registered outputs; seg_out and dig_en share one enable so they never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ready_r <= 1'b1;
            bcd_out_r  <= BCD_ZERO;
            seg_out_r  <= 7'd0;
            dig_en_r   <= {NUM_DIGITS{1'b0}};
        end else begin
            wr_ready_r <= !copy_s;
            if (copy_s) begin
                bcd_out_r <= shadow_n[idx_s];
            end else begin
                bcd_out_r <= active_r[idx_s];
            end
            if (lit_s) begin
                seg_out_r <= seg_in;
                dig_en_r  <= NUM_DIGITS'(1) << idx_s;
            end else begin
                seg_out_r <= 7'd0;
                dig_en_r  <= {NUM_DIGITS{1'b0}};
            end
        end
    end

    assign wr_ready = wr_ready_r;
    assign bcd_out  = bcd_out_r;
    assign seg_out  = seg_out_r;
    assign dig_en   = dig_en_r;

endmodule
